// File: rtl/uart_loader_ctrl.sv
// UART boot loader: parses sync/count/data/checksum frames from a received byte stream
// and writes little-endian 32-bit words into a memory port shared with the CPU.
module uart_loader_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam int              TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;
    localparam logic [7:0]      SYNC      = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [15:0]       r_count;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_word_idx;
    logic [7:0]        r_csum;
    logic              r_wr_pend;
    logic              r_done;
    logic              r_error;
    logic [15:0]       r_words_loaded;
    logic [TO_W-1:0]   r_idle_cnt;

    logic              w_busy;
    logic              w_own;
    logic              w_sync;
    logic              w_timeout;
    logic              w_word_done;
    logic              w_last_word;
    logic [16:0]       w_count_full;

    assign w_busy = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                    (r_state == S_DATA)   || (r_state == S_CSUM);

    assign w_sync = rx_valid && (rx_data == SYNC) &&
                    ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

    assign w_timeout    = w_busy && !rx_valid && (r_idle_cnt == TO_LAST);
    assign w_word_done  = rx_valid && (r_state == S_DATA) && (r_byte_idx == 2'd3);
    assign w_last_word  = (r_words_loaded + 16'd1) == r_count;
    assign w_count_full = {1'b0, rx_data, r_count[7:0]};

    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_sync) w_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (rx_valid) w_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (rx_valid) begin
                    if (w_count_full > MAX_WORDS)  w_next = S_ERROR;
                    else if (w_count_full == '0)   w_next = S_CSUM;
                    else                           w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_done && w_last_word) w_next = S_CSUM;
            end
            S_CSUM: begin
                if (rx_valid) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERROR;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count        <= '0;
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_word_idx     <= '0;
            r_csum         <= '0;
            r_wr_pend      <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
            r_idle_cnt     <= '0;
        end else begin
            // NOTE: non-blocking updates so each register samples only pre-edge values.
            r_wr_pend <= 1'b0;

            if (rx_valid || !w_busy) r_idle_cnt <= '0;
            else                     r_idle_cnt <= r_idle_cnt + 1'b1;

            // The word index advances once the pending word has been presented on the port.
            if (r_wr_pend) r_word_idx <= r_word_idx + 1'b1;

            if (w_sync) begin
                r_done         <= 1'b0;
                r_error        <= 1'b0;
                r_words_loaded <= '0;
                r_word_idx     <= '0;
                r_csum         <= '0;
                r_byte_idx     <= '0;
            end

            if (rx_valid) begin
                case (r_state)
                    S_CNT_LO: r_count[7:0]  <= rx_data;
                    S_CNT_HI: r_count[15:8] <= rx_data;
                    S_DATA: begin
                        r_csum     <= r_csum ^ rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_word     <= {rx_data, r_word[31:8]};
                        if (r_byte_idx == 2'd3) begin
                            r_wr_pend      <= 1'b1;
                            r_words_loaded <= r_words_loaded + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end

            if ((r_state == S_CSUM) && (w_next == S_DONE)) r_done <= 1'b1;
            if ((r_state != S_ERROR) && (w_next == S_ERROR)) r_error <= 1'b1;
        end
    end

    // A pending loader write keeps the port even if the frame state has already moved on.
    assign w_own     = w_busy || r_wr_pend;
    assign mem_we    = w_own ? r_wr_pend  : cpu_we;
    assign mem_addr  = w_own ? r_word_idx : cpu_addr;
    assign mem_wdata = w_own ? r_word     : cpu_wdata;

    assign cpu_stall    = w_own;
    assign busy         = w_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Scoreboard bench for uart_loader_ctrl: stimulus queues expected memory writes from the
// frame bytes, a negedge monitor pops and compares every write seen on the memory port.
`timescale 1ns/1ps
module tb_uart_loader_ctrl;

    localparam int ADDR_W  = 14;
    localparam int TIMEOUT = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [31:0]       cpu_wdata = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_stall;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    uart_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_stall   (cpu_stall),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int unsigned       cyc;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write on the memory port must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected (t=%0t)",
                         mem_addr, mem_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
                check("wr_data", 64'(mem_wdata), 64'(mon_e.data));
                check("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Reference model: final status of a frame from the framing rules alone.
    function automatic void model(input bq_t b, output bit d, output bit e, output int unsigned w);
        int         s = -1;
        int         n;
        int         avail;
        logic [7:0] x = 8'h00;
        d = 1'b0;
        e = 1'b0;
        w = 0;
        foreach (b[i]) if (s < 0 && b[i] == 8'hA5) s = i;
        if (s < 0) return;
        n = int'({b[s+2], b[s+1]});
        if (n > 2**ADDR_W) begin
            e = 1'b1;
            return;
        end
        avail = b.size() - s - 3;
        if (avail < 4*n + 1) begin
            e = 1'b1;
            w = (avail / 4 < n) ? avail / 4 : n;
            return;
        end
        for (int k = 0; k < 4*n; k++) x ^= b[s+3+k];
        w = n;
        if (b[s+3+4*n] == x) d = 1'b1;
        else                 e = 1'b1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic cpu_poke_idle();
        wr_t e;
        cpu_we    = 1'b1;
        cpu_addr  = ADDR_W'(5);
        cpu_wdata = 32'hDEADBEEF;
        e.addr = ADDR_W'(5);
        e.data = 32'hDEADBEEF;
        e.cyc  = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        check("cpu_stall_idle", 64'(cpu_stall), 64'd0);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
    endtask

    task automatic cpu_poke_stalled();
        cpu_we    = 1'b1;
        cpu_addr  = ADDR_W'(5);
        cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("cpu_stall_busy", 64'(cpu_stall), 64'd1);
        @(posedge clk);
        #1;
        tick(1);
        cpu_we = 1'b0;
    endtask

    task automatic send_frame(input bq_t b, input int max_gap, input bit poke);
        int s = -1;
        int n = 0;
        foreach (b[i]) if (s < 0 && b[i] == 8'hA5) s = i;
        if (s >= 0 && b.size() > s + 2) n = int'({b[s+2], b[s+1]});
        if (n > 2**ADDR_W) n = 0;
        for (int i = 0; i < b.size(); i++) begin
            int j = i - s - 3;
            if (s >= 0 && j >= 0 && j < 4*n && j % 4 == 3) begin
                wr_t e;
                e.addr = ADDR_W'(j / 4);
                e.data = {b[i], b[i-1], b[i-2], b[i-3]};
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
            send_byte(b[i]);
            if (poke && s >= 0 && n > 0 && j == 1) cpu_poke_stalled();
            if (i < b.size() - 1) tick($urandom_range(max_gap, 0));
        end
    endtask

    task automatic check_status(input bq_t b);
        bit          d;
        bit          e;
        int unsigned w;
        model(b, d, e, w);
        tick(2);
        @(negedge clk);
        check("done", 64'(done), 64'(d));
        check("error", 64'(error), 64'(e));
        check("words_loaded", 64'(words_loaded), 64'(w));
        check("busy_after", 64'(busy), 64'd0);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t        f_good;
        bq_t        f_bad;
        bq_t        f_zero;
        bq_t        f_big;
        bq_t        f_to;
        bq_t        f_rnd;
        int         k;
        int         n;
        logic [7:0] x;
        logic [7:0] v;

        // XOR of 11..88 is 0x88, which makes this the good-checksum frame.
        f_good = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        f_bad  = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h09};
        f_zero = {8'hA5, 8'h00, 8'h00, 8'h00};
        f_big  = {8'hA5, 8'h01, 8'h40};
        f_to   = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00};

        tick(3);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);

        cpu_poke_idle();

        send_frame(f_good, 2, 1'b1);
        check_status(f_good);

        send_frame(f_bad, 1, 1'b0);
        check_status(f_bad);

        send_frame(f_zero, 0, 1'b0);
        check_status(f_zero);

        send_frame(f_big, 0, 1'b0);
        check_status(f_big);

        send_frame(f_to, 0, 1'b0);
        @(negedge clk);
        check("to_busy_start", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        tick(TIMEOUT - 4);
        @(negedge clk);
        check("to_not_early", 64'(error), 64'd0);
        k = 0;
        while (error !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("to_error", 64'(error), 64'd1);
        check("to_busy_fall", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_status(f_to);

        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_words", 64'(words_loaded), 64'd0);
        check("abort_mem_we", 64'(mem_we), 64'd0);
        check("abort_stall", 64'(cpu_stall), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        send_frame(f_good, 0, 1'b0);
        check_status(f_good);

        for (int it = 0; it < 8; it++) begin
            f_rnd = {};
            repeat ($urandom_range(2, 0)) begin
                v = 8'($urandom_range(255, 0));
                if (v == 8'hA5) v = 8'h5A;
                f_rnd.push_back(v);
            end
            n = $urandom_range(6, 1);
            f_rnd.push_back(8'hA5);
            f_rnd.push_back(8'(n));
            f_rnd.push_back(8'(n >> 8));
            x = 8'h00;
            for (int i = 0; i < 4*n; i++) begin
                v = 8'($urandom_range(255, 0));
                x ^= v;
                f_rnd.push_back(v);
            end
            if ($urandom_range(1, 0) == 1) x ^= 8'($urandom_range(255, 1));
            f_rnd.push_back(x);
            send_frame(f_rnd, 3, it[0]);
            check_status(f_rnd);
        end

        cpu_poke_idle();
        tick(3);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
